// File: rtl/mac_matrix_engine.sv
// 4x4 (DIM x DIM) int8 matrix multiply engine: one signed 8x8 multiplier, one accumulator,
// saturated int8 results written back into Weight memory starting at RES_BASE.
module mac_matrix_engine #(
   parameter int DIM       = 4,
   parameter int ACC_W     = 20,
   parameter int OUT_SHIFT = 0,
   parameter int RES_BASE  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic                            a_rd_en,
   output logic [$clog2(DIM*DIM)-1:0]      a_addr,
   input  logic signed [7:0]               a_rdata,
   output logic                            w_rd_en,
   output logic [$clog2(2*DIM*DIM)-1:0]    w_addr,
   input  logic signed [7:0]               w_rdata,
   output logic                            res_we,
   output logic [$clog2(2*DIM*DIM)-1:0]    res_addr,
   output logic signed [7:0]               res_data,
   output logic signed [ACC_W-1:0]         acc_out
);

   localparam int KW  = $clog2(DIM);
   localparam int AW  = $clog2(DIM*DIM);
   localparam int WAW = $clog2(2*DIM*DIM);

   localparam logic [KW-1:0] K_ZERO = KW'(1'b0);
   localparam logic [KW-1:0] K_ONE  = KW'(1'b1);
   localparam logic [KW-1:0] K_LAST = KW'(DIM-1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-8){1'b0}}, 8'h7F};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-8){1'b1}}, 8'h80};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                   state_r, state_nxt_s;
   logic [KW-1:0]            k_r, k_nxt_s;
   logic [KW-1:0]            r_r, r_nxt_s;
   logic [KW-1:0]            c_r, c_nxt_s;
   logic signed [ACC_W-1:0]  acc_r, acc_nxt_s;
   logic                     wr_s;

   logic signed [15:0]       prod_s;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  sum_s;
   logic signed [ACC_W-1:0]  shifted_s;
   logic [WAW-1:0]           res_addr_s;

   // Clamp a full-precision value into the int8 range.
   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
      logic signed [7:0] res;
      if (v > SAT_MAX) begin
         res = 8'sh7F;
      end else if (v < SAT_MIN) begin
         res = 8'sh80;
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   assign prod_s     = $signed({{8{a_rdata[7]}}, a_rdata}) * $signed({{8{w_rdata[7]}}, w_rdata});
   assign prod_ext_s = {{(ACC_W-16){prod_s[15]}}, prod_s};
   // The k=DIM-1 product arrives during WRITE and is folded in without touching acc_r.
   assign sum_s      = acc_r + prod_ext_s;
   assign shifted_s  = sum_s >>> OUT_SHIFT;
   assign res_addr_s = WAW'(RES_BASE) + {1'b0, r_r, c_r};

   // Next-state, counter and accumulator logic.
   always_comb begin
      state_nxt_s = state_r;
      k_nxt_s     = k_r;
      r_nxt_s     = r_r;
      c_nxt_s     = c_r;
      acc_nxt_s   = acc_r;
      wr_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_RUN;
               k_nxt_s     = K_ZERO;
               r_nxt_s     = K_ZERO;
               c_nxt_s     = K_ZERO;
               acc_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Data returning at k=0 belongs to no read of this element.
            if (k_r == K_ZERO) begin
               acc_nxt_s = acc_r;
            end else if (k_r == K_ONE) begin
               acc_nxt_s = prod_ext_s;
            end else begin
               acc_nxt_s = sum_s;
            end
            if (k_r == K_LAST) begin
               state_nxt_s = ST_WRITE;
               k_nxt_s     = K_ZERO;
            end else begin
               k_nxt_s     = k_r + K_ONE;
            end
         end
         ST_WRITE: begin
            wr_s    = 1'b1;
            k_nxt_s = K_ZERO;
            if (c_r == K_LAST) begin
               c_nxt_s = K_ZERO;
               if (r_r == K_LAST) begin
                  r_nxt_s     = K_ZERO;
                  state_nxt_s = ST_DONE;
               end else begin
                  r_nxt_s     = r_r + K_ONE;
                  state_nxt_s = ST_RUN;
               end
            end else begin
               c_nxt_s     = c_r + K_ONE;
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            k_nxt_s     = K_ZERO;
            r_nxt_s     = K_ZERO;
            c_nxt_s     = K_ZERO;
            acc_nxt_s   = '0;
         end
      endcase
   end

   // State, loop counters and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         k_r     <= K_ZERO;
         r_r     <= K_ZERO;
         c_r     <= K_ZERO;
         acc_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         k_r     <= k_nxt_s;
         r_r     <= r_nxt_s;
         c_r     <= c_nxt_s;
         acc_r   <= acc_nxt_s;
      end
   end

   // Registered outputs, derived from the upcoming state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         a_rd_en  <= 1'b0;
         w_rd_en  <= 1'b0;
         a_addr   <= '0;
         w_addr   <= '0;
         res_we   <= 1'b0;
         res_addr <= '0;
         res_data <= '0;
         acc_out  <= '0;
      end else begin
         busy    <= (state_nxt_s != ST_IDLE);
         done    <= (state_nxt_s == ST_DONE);
         a_rd_en <= (state_nxt_s == ST_RUN);
         w_rd_en <= (state_nxt_s == ST_RUN);
         if (state_nxt_s == ST_RUN) begin
            a_addr <= AW'({r_nxt_s, k_nxt_s});
            w_addr <= WAW'({1'b0, k_nxt_s, c_nxt_s});
         end else begin
            a_addr <= '0;
            w_addr <= '0;
         end
         res_we <= wr_s;
         if (wr_s) begin
            res_addr <= res_addr_s;
            res_data <= sat8(shifted_s);
            acc_out  <= sum_s;
         end else begin
            res_addr <= res_addr;
            res_data <= res_data;
            acc_out  <= acc_out;
         end
      end
   end

endmodule

// File: tb/tb_mac_matrix_engine.sv
// Bench for mac_matrix_engine: two instances (OUT_SHIFT 0 and 8) share the loader memories
// and are scored against a plain matrix-product model.
module tb_mac_matrix_engine;

   logic clk = 1'b0;
   logic rst_n;
   logic start;

   logic [1:0]        busy, done, a_rd_en, w_rd_en, res_we;
   logic [3:0]        a_addr [2];
   logic [4:0]        w_addr [2];
   logic [4:0]        res_addr [2];
   logic signed [7:0] a_rdata [2];
   logic signed [7:0] w_rdata [2];
   logic signed [7:0] res_data [2];
   logic signed [19:0] acc_out [2];

   logic signed [7:0] a_mem [16];
   logic signed [7:0] w_mem [32];

   typedef struct {
      int addr;
      int acc;
      int d0;
      int d1;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks  = 0;
   int errors  = 0;
   int wr_cnt  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   mac_matrix_engine #(.DIM(4), .ACC_W(20), .OUT_SHIFT(0), .RES_BASE(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
      .a_rd_en(a_rd_en[0]), .a_addr(a_addr[0]), .a_rdata(a_rdata[0]),
      .w_rd_en(w_rd_en[0]), .w_addr(w_addr[0]), .w_rdata(w_rdata[0]),
      .res_we(res_we[0]), .res_addr(res_addr[0]), .res_data(res_data[0]), .acc_out(acc_out[0])
   );

   mac_matrix_engine #(.DIM(4), .ACC_W(20), .OUT_SHIFT(8), .RES_BASE(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
      .a_rd_en(a_rd_en[1]), .a_addr(a_addr[1]), .a_rdata(a_rdata[1]),
      .w_rd_en(w_rd_en[1]), .w_addr(w_addr[1]), .w_rdata(w_rdata[1]),
      .res_we(res_we[1]), .res_addr(res_addr[1]), .res_data(res_data[1]), .acc_out(acc_out[1])
   );

   // Synchronous-read loader memories, one read port per engine.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (a_rd_en[i]) a_rdata[i] <= a_mem[a_addr[i]];
         if (w_rd_en[i]) w_rdata[i] <= w_mem[w_addr[i]];
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 127) return 127;
      else if (v < -128) return -128;
      else return v;
   endfunction

   // Reference: C = A x W, elements in row-major order.
   task automatic build_expect();
      int s;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(a_mem[r*4+k]) * int'(w_mem[k*4+c]);
            q.push_back('{16 + r*4 + c, s, sat(s), sat(s >>> 8)});
         end
      end
   endtask

   task automatic load_identity();
      for (int i = 0; i < 32; i++) w_mem[i] = 8'sd0;
      for (int i = 0; i < 16; i++) begin
         a_mem[i] = 8'(i);
         w_mem[i] = (i / 4 == i % 4) ? 8'sd1 : 8'sd0;
      end
   endtask

   task automatic load_fill(input int a, input int w);
      for (int i = 0; i < 32; i++) w_mem[i] = 8'sd0;
      for (int i = 0; i < 16; i++) begin
         a_mem[i] = 8'(a);
         w_mem[i] = 8'(w);
      end
   endtask

   task automatic load_mix();
      for (int i = 0; i < 32; i++) w_mem[i] = 8'sd0;
      for (int i = 0; i < 16; i++) begin
         a_mem[i] = 8'(i*9 - 70);
         w_mem[i] = 8'(50 - i*7);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_busy%0d", tag, i), busy[i], 0);
         chk($sformatf("%s_done%0d", tag, i), done[i], 0);
         chk($sformatf("%s_ard%0d", tag, i), a_rd_en[i], 0);
         chk($sformatf("%s_wrd%0d", tag, i), w_rd_en[i], 0);
         chk($sformatf("%s_aaddr%0d", tag, i), a_addr[i], 0);
         chk($sformatf("%s_waddr%0d", tag, i), w_addr[i], 0);
         chk($sformatf("%s_we%0d", tag, i), res_we[i], 0);
         chk($sformatf("%s_raddr%0d", tag, i), res_addr[i], 0);
         chk($sformatf("%s_rdata%0d", tag, i), res_data[i], 0);
         chk($sformatf("%s_acc%0d", tag, i), acc_out[i], 0);
      end
   endtask

   // Scoreboard: every write strobe is matched against the next expected element.
   always @(negedge clk) begin
      if (res_we[0] || res_we[1]) begin
         wr_cnt++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_write: got write at addr %0d expected none", res_addr[0]);
         end else begin
            e = q.pop_front();
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("we%0d", i), res_we[i], 1);
               chk($sformatf("addr%0d", i), res_addr[i], e.addr);
               chk($sformatf("acc%0d@%0d", i, e.addr), acc_out[i], e.acc);
               chk($sformatf("data%0d@%0d", i, e.addr), res_data[i], (i == 0) ? e.d0 : e.d1);
            end
         end
      end
      if (done[0]) done_cnt++;
   end

   // One full run; start accepted at the next edge (E0), done expected in the cycle after E0+80.
   task automatic run_check(input string tag, input int pulse_at);
      int wr_base, dc_base, done_n;
      wr_base = wr_cnt;
      dc_base = done_cnt;
      done_n  = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 200 && done_n == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk({tag, "_busy_first0"}, busy[0], 1);
            chk({tag, "_busy_first1"}, busy[1], 1);
         end
         if (pulse_at > 0 && n == pulse_at) start = 1'b1;
         if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
         if (done[0]) begin
            done_n = n;
            chk({tag, "_done_with_we"}, res_we[0], 1);
            chk({tag, "_done1"}, done[1], 1);
         end
      end
      chk({tag, "_done_latency"}, done_n, 81);
      repeat (3) @(negedge clk);
      chk({tag, "_writes"}, wr_cnt - wr_base, 16);
      chk({tag, "_dones"}, done_cnt - dc_base, 1);
      chk({tag, "_pending"}, q.size(), 0);
      chk({tag, "_busy_after"}, busy[0], 0);
   endtask

   initial begin
      int wr_base, dc_base, done_n, n2;
      rst_n = 1'b0;
      start = 1'b0;
      load_identity();
      repeat (3) @(negedge clk);
      #1 check_idle("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("post_rst");

      // Identity weights: results equal A, addresses 16..31.
      load_identity();
      build_expect();
      chk("model_id_c12", q[6].acc, 6);
      chk("model_id_c33", q[15].d0, 15);
      chk("model_id_addr0", q[0].addr, 16);
      run_check("ident", 0);

      // Positive saturation.
      load_fill(127, 127);
      build_expect();
      chk("model_pos_acc", q[0].acc, 64516);
      chk("model_pos_d0", q[0].d0, 127);
      chk("model_pos_d1", q[0].d1, 127);
      run_check("satpos", 0);

      // Negative saturation.
      load_fill(-128, 127);
      build_expect();
      chk("model_neg_acc", q[5].acc, -65024);
      chk("model_neg_d0", q[5].d0, -128);
      chk("model_neg_d1", q[5].d1, -128);
      run_check("satneg", 0);

      // Shifted instance brings 1024 back into range.
      load_fill(16, 16);
      build_expect();
      chk("model_sh_acc", q[9].acc, 1024);
      chk("model_sh_d1", q[9].d1, 4);
      chk("model_sh_d0", q[9].d0, 127);
      run_check("shift", 0);

      // A second start mid-run must be ignored.
      load_identity();
      build_expect();
      run_check("restart_ign", 10);

      // Reset right after the 5th write aborts; a new start recomputes from element 0.
      build_expect();
      wr_base = wr_cnt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 0; n < 120 && (wr_cnt - wr_base) < 5; n++) begin
         @(negedge clk);
         #1;
      end
      chk("abort_wr5", wr_cnt - wr_base, 5);
      rst_n = 1'b0;
      #1 check_idle("abort");
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      build_expect();
      chk("model_abort_addr0", q[0].addr, 16);
      run_check("after_abort", 0);

      // Start held high: back-to-back runs with mixed-sign data.
      load_mix();
      build_expect();
      build_expect();
      chk("model_mix_acc", q[0].acc, -3068);
      chk("model_mix_d0", q[0].d0, -128);
      chk("model_mix_d1", q[0].d1, -12);
      wr_base = wr_cnt;
      dc_base = done_cnt;
      done_n  = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 200 && done_n == 0; n++) begin
         @(negedge clk);
         if (done[0]) done_n = n;
      end
      chk("held_done1", done_n, 81);
      @(negedge clk);
      chk("held_idle_busy", busy[0], 0);
      @(negedge clk);
      chk("held_rerun_busy", busy[0], 1);
      start = 1'b0;
      n2 = 0;
      for (int n = 84; n <= 300 && n2 == 0; n++) begin
         @(negedge clk);
         if (done[0]) n2 = n;
      end
      chk("held_done2", n2, 163);
      repeat (3) @(negedge clk);
      chk("held_writes", wr_cnt - wr_base, 32);
      chk("held_dones", done_cnt - dc_base, 2);
      chk("held_pending", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
